// File: rtl/bht_port_arbiter.sv
// Single-port BHT SRAM scheduler: lookups win, updates queue in a FIFO and drain as read-modify-write.
// Optional perf counters are enabled with `define BHT_ARB_PERF_EN.
module bht_port_arbiter #(
  parameter int          IDX_W        = 8,
  parameter int          UPD_DEPTH    = 4,
  parameter int          STARVE_LIMIT = 8,
  parameter logic [1:0]  INIT_CTR     = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_done,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_index,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [1:0]       rsp_counter,
  output logic             rsp_taken,
  input  logic             fb_valid,
  input  logic [IDX_W-1:0] fb_index,
  input  logic             fb_outcome,
  output logic             fb_ready,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [1:0]       mem_wdata,
  input  logic [1:0]       mem_rdata
`ifdef BHT_ARB_PERF_EN
  ,
  output logic [31:0]      perf_lookup_stall,
  output logic [31:0]      perf_update_cnt,
  output logic [31:0]      perf_starve_cnt
`endif
);

  localparam int               PW       = $clog2(UPD_DEPTH);
  localparam logic [7:0]       STARVE_L = 8'(STARVE_LIMIT);
  localparam logic [PW:0]      P_ONE    = 1;
  localparam logic [IDX_W-1:0] I_ONE    = 1;

  typedef enum logic [1:0] {INIT, IDLE, UPD_WR} state_t;

  state_t           state;
  logic [IDX_W-1:0] init_ptr;
  logic [7:0]       age;

  logic [IDX_W-1:0] fifo_idx [UPD_DEPTH];
  logic             fifo_out [UPD_DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic [IDX_W-1:0] head_idx;
  logic             head_out;

  logic upd_go, starve, grant, push, pop;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_idx   = fifo_idx[rd_ptr[PW-1:0]];
  assign head_out   = fifo_out[rd_ptr[PW-1:0]];

  // Port decisions are combinational so a lookup is granted in the cycle it is presented.
  assign starve = (age >= STARVE_L);
  assign upd_go = ~rst && (state == IDLE) && ~fifo_empty && (fifo_full || starve || ~req_valid);
  assign grant  = ~rst && (state == IDLE) && req_valid && ~upd_go;
  assign push   = fb_valid && fb_ready;
  assign pop    = ~rst && (state == UPD_WR);

  assign req_ready   = grant;
  assign fb_ready    = ~rst && init_done && ~fifo_full;
  assign rsp_counter = rsp_valid ? mem_rdata : 2'b00;
  assign rsp_taken   = rsp_counter[1];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 2'b00;
    if (!rst) begin
      case (state)
        INIT: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = init_ptr;
          mem_wdata = INIT_CTR;
        end
        IDLE: begin
          if (upd_go) begin
            mem_en   = 1'b1;
            mem_addr = head_idx;
          end else if (grant) begin
            mem_en   = 1'b1;
            mem_addr = req_index;
          end
        end
        UPD_WR: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = head_idx;
          mem_wdata = head_out ? sat_inc(mem_rdata) : sat_dec(mem_rdata);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      init_ptr  <= '0;
      init_done <= 1'b0;
      age       <= 8'd0;
      rsp_valid <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      rsp_valid <= grant;
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
      case (state)
        INIT: begin
          init_ptr <= init_ptr + I_ONE;
          if (init_ptr == '1) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (upd_go) begin
            state <= UPD_WR;
            age   <= 8'd0;
          end else if (grant && !fifo_empty && age != 8'hFF) begin
            // Only a head held off by a granted lookup ages.
            age <= age + 8'd1;
          end
        end
        UPD_WR:  state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr[PW-1:0]] <= fb_index;
      fifo_out[wr_ptr[PW-1:0]] <= fb_outcome;
    end
  end

`ifdef BHT_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lookup_stall <= '0;
      perf_update_cnt   <= '0;
      perf_starve_cnt   <= '0;
    end else begin
      if (req_valid && !req_ready && init_done && perf_lookup_stall != '1)
        perf_lookup_stall <= perf_lookup_stall + 32'd1;
      if (pop && perf_update_cnt != '1)
        perf_update_cnt <= perf_update_cnt + 32'd1;
      if (upd_go && starve && perf_starve_cnt != '1)
        perf_starve_cnt <= perf_starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bht_port_arbiter.sv
// Bench for bht_port_arbiter: behavioural SRAM, lookup scoreboard and directed scenarios at IDX_W=4.
module tb_bht_port_arbiter;
  localparam int IDX_W = 4;
  localparam int N     = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             init_done;
  logic             req_valid;
  logic [IDX_W-1:0] req_index;
  logic             req_ready;
  logic             rsp_valid;
  logic [1:0]       rsp_counter;
  logic             rsp_taken;
  logic             fb_valid;
  logic [IDX_W-1:0] fb_index;
  logic             fb_outcome;
  logic             fb_ready;
  logic             mem_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [1:0]       mem_wdata;
  logic [1:0]       mem_rdata;
`ifdef BHT_ARB_PERF_EN
  logic [31:0]      perf_lookup_stall, perf_update_cnt, perf_starve_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]       sram    [N];
  logic [1:0]       exp_tbl [N];
  logic [1:0]       sb      [$];
  logic [5:0]       wlog    [$];

  always #5 clk = ~clk;

  bht_port_arbiter #(.IDX_W(IDX_W), .UPD_DEPTH(4), .STARVE_LIMIT(8), .INIT_CTR(2'b01)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_counter(rsp_counter), .rsp_taken(rsp_taken),
    .fb_valid(fb_valid), .fb_index(fb_index), .fb_outcome(fb_outcome), .fb_ready(fb_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef BHT_ARB_PERF_EN
    , .perf_lookup_stall(perf_lookup_stall), .perf_update_cnt(perf_update_cnt),
    .perf_starve_cnt(perf_starve_cnt)
`endif
  );

  // SRAM: read data one cycle after the read, writes visible to the next read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Scoreboard: expected counter queued on acceptance, compared on the response cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          logic [1:0] e;
          e = sb.pop_front();
          chk("rsp_counter", 32'(rsp_counter), 32'(e));
          chk("rsp_taken", 32'(rsp_taken), 32'(e[1]));
        end
      end
      if (req_valid && req_ready) sb.push_back(exp_tbl[req_index]);
      if (mem_en && mem_we && init_done) wlog.push_back({mem_addr, mem_wdata});
    end
  end

  task automatic init_walk;
    req_valid = 1'b1;
    req_index = 4'd0;
    for (int i = 0; i < N; i++) begin
      smp;
      chk("init_wr", 32'(mem_en && mem_we), 32'd1);
      chk("init_addr", 32'(mem_addr), 32'(i));
      chk("init_wdata", 32'(mem_wdata), 32'd1);
      chk("init_req_ready", 32'(req_ready), 32'd0);
      chk("init_fb_ready", 32'(fb_ready), 32'd0);
      chk("init_done_low", 32'(init_done), 32'd0);
      nxt;
    end
    req_valid = 1'b0;
    smp;
    chk("init_done", 32'(init_done), 32'd1);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("idle_fb_ready", 32'(fb_ready), 32'd1);
    nxt;
  endtask

  task automatic lookup(input logic [IDX_W-1:0] idx, input logic taken);
    req_valid = 1'b1;
    req_index = idx;
    smp;
    chk("lk_ready", 32'(req_ready), 32'd1);
    chk("lk_rd", 32'({mem_en, mem_we}), 32'b10);
    chk("lk_addr", 32'(mem_addr), 32'(idx));
    nxt;
    req_valid = 1'b0;
    smp;
    chk("lk_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lk_taken", 32'(rsp_taken), 32'(taken));
    nxt;
    smp;
    chk("lk_rsp_low", 32'(rsp_valid), 32'd0);
    nxt;
  endtask

  function automatic logic [1:0] upd(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int grants;
    rst = 1'b1; req_valid = 1'b1; req_index = '0;
    fb_valid = 1'b0; fb_index = '0; fb_outcome = 1'b0;
    for (int i = 0; i < N; i++) exp_tbl[i] = 2'b01;
    repeat (3) nxt;
    smp;
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_fb_ready", 32'(fb_ready), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    nxt;
    rst = 1'b0;
    init_walk();

    // Plain lookup after init.
    lookup(4'd5, 1'b0);

    // Idle updates: three taken pushes to entry 3, drained with no lookups.
    wlog.delete();
    fb_valid = 1'b1; fb_index = 4'd3; fb_outcome = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp;
      chk("idle_fb_ready", 32'(fb_ready), 32'd1);
      if (k == 1) chk("idle_upd_rd", 32'({mem_en, mem_we, mem_addr}), 32'({2'b10, 4'd3}));
      if (k == 2) chk("idle_upd_wr", 32'({mem_en, mem_we, mem_addr}), 32'({2'b11, 4'd3}));
      exp_tbl[3] = upd(exp_tbl[3], 1'b1);
      nxt;
    end
    fb_valid = 1'b0;
    repeat (8) nxt;
    chk("idle_wr_count", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("idle_wr0", 32'(wlog[0]), 32'({4'd3, 2'd2}));
      chk("idle_wr1", 32'(wlog[1]), 32'({4'd3, 2'd3}));
      chk("idle_wr2", 32'(wlog[2]), 32'({4'd3, 2'd3}));
    end
    chk("idle_sram3", 32'(sram[3]), 32'd3);
    lookup(4'd3, 1'b1);

    // Starvation: one queued update against continuous lookups.
    req_valid = 1'b1; req_index = 4'd7;
    fb_valid = 1'b1; fb_index = 4'd10; fb_outcome = 1'b0;
    exp_tbl[10] = upd(exp_tbl[10], 1'b0);
    smp;
    chk("stv_first_ready", 32'(req_ready), 32'd1);
    nxt;
    fb_valid = 1'b0;
    grants = 0;
    for (int c = 0; c < 20; c++) begin
      smp;
      if (!req_ready) break;
      grants++;
      nxt;
    end
    chk("stv_grants", 32'(grants), 32'd8);
    chk("stv_rd", 32'({mem_en, mem_we, mem_addr}), 32'({2'b10, 4'd10}));
    nxt;
    smp;
    chk("stv_wr", 32'({mem_en, mem_we, mem_wdata}), 32'({2'b11, 2'd0}));
    chk("stv_wr_ready", 32'(req_ready), 32'd0);
    nxt;
    smp;
    chk("stv_resume", 32'(req_ready), 32'd1);
    nxt;
    req_valid = 1'b0;
    repeat (2) nxt;

    // Full FIFO forces an update under continuous lookups.
    req_valid = 1'b1; req_index = 4'd9;
    fb_valid = 1'b1; fb_index = 4'd12; fb_outcome = 1'b1;
    for (int k = 0; k < 4; k++) begin
      smp;
      chk("full_fb_ready", 32'(fb_ready), 32'd1);
      chk("full_req_ready", 32'(req_ready), 32'd1);
      exp_tbl[12] = upd(exp_tbl[12], 1'b1);
      nxt;
    end
    fb_valid = 1'b0;
    smp;
    chk("full_fb_low", 32'(fb_ready), 32'd0);
    chk("full_forced", 32'({req_ready, mem_en, mem_we, mem_addr}), 32'({3'b010, 4'd12}));
    nxt;
    smp;
    chk("full_wr", 32'({fb_ready, mem_we}), 32'b01);
    nxt;
    smp;
    chk("full_fb_back", 32'(fb_ready), 32'd1);
    chk("full_req_back", 32'(req_ready), 32'd1);
    nxt;
    req_valid = 1'b0;
    repeat (10) nxt;
    lookup(4'd12, 1'b1);
    lookup(4'd10, 1'b0);

    // Reset during UPD_WR with three entries queued.
    req_valid = 1'b1; req_index = 4'd0;
    fb_valid = 1'b1; fb_index = 4'd5; fb_outcome = 1'b1;
    repeat (3) begin smp; nxt; end
    fb_valid = 1'b0; req_valid = 1'b0;
    smp;
    chk("rmo_rd", 32'({mem_en, mem_we, mem_addr}), 32'({2'b10, 4'd5}));
    nxt;
    smp;
    chk("rmo_wr", 32'(mem_we), 32'd1);
    rst = 1'b1;
    nxt;
    smp;
    chk("rmo_mem_en", 32'(mem_en), 32'd0);
    chk("rmo_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rmo_fb_ready", 32'(fb_ready), 32'd0);
    chk("rmo_init_done", 32'(init_done), 32'd0);
    chk("rmo_no_write", 32'(sram[5]), 32'd1);
    nxt;
    rst = 1'b0;
    for (int i = 0; i < N; i++) exp_tbl[i] = 2'b01;
    init_walk();
    lookup(4'd5, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
